// File: rtl/sdrc_arb_pkg.sv
// Shared types and helpers for the SDRAM-controller Wishbone arbiter.
package sdrc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    // Up to 8 masters; caller zero-extends and truncates to its own width.
    function automatic logic [2:0] onehot2bin(input logic [7:0] oh);
        logic [2:0] bin;
        bin = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                bin = bin | 3'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/sdrc_rr_picker.sv
// Combinational circular-priority picker: first requester at or after ptr.
module sdrc_rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [N-1:0] rot_req;
    logic [N-1:0] rot_gnt;

    // Rotate so the pointer position becomes bit 0, pick lowest, rotate back.
    assign rot_req = N'({req, req} >> ptr);

    always_comb begin
        rot_gnt = '0;
        valid   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rot_req[i] && !valid) begin
                rot_gnt[i] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

    assign gnt = N'(({rot_gnt, rot_gnt} << ptr) >> N);

endmodule

// File: rtl/sdrc_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the SDRAM controller slave port,
// with a stall watchdog that aborts a hung cycle with ERR.
module sdrc_wb_arbiter
    import sdrc_arb_pkg::*;
#(
    parameter int NUM_M   = 4,
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  sys_clk,
    input  logic                  RESETN,
    input  logic [NUM_M-1:0]      m_cyc_i,
    input  logic [NUM_M-1:0]      m_stb_i,
    input  logic [NUM_M-1:0]      m_we_i,
    input  logic [NUM_M*AW-1:0]   m_adr_i,
    input  logic [NUM_M*DW-1:0]   m_dat_i,
    input  logic [NUM_M*DW/8-1:0] m_sel_i,
    input  logic [NUM_M*3-1:0]    m_cti_i,
    output logic [NUM_M-1:0]      m_ack_o,
    output logic [NUM_M-1:0]      m_err_o,
    output logic [DW-1:0]         m_dat_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [DW/8-1:0]       s_sel_o,
    output logic [2:0]            s_cti_o,
    input  logic                  s_ack_i,
    input  logic [DW-1:0]         s_dat_i,
    output logic [NUM_M-1:0]      grant_o,
    output logic                  busy_o
);

    localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int SW = DW / 8;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
    localparam logic [WW-1:0] WD_SAT  = WW'(TIMEOUT);

    arb_state_e       state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WW-1:0]    wd_q, wd_d;

    logic [NUM_M-1:0] pick_gnt;
    logic             pick_valid;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    ptr_adv;
    logic             stall;
    logic             timeout;

    logic [AW-1:0] adr_a [NUM_M];
    logic [DW-1:0] dat_a [NUM_M];
    logic [SW-1:0] sel_a [NUM_M];
    logic [2:0]    cti_a [NUM_M];

    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
            assign adr_a[gi] = m_adr_i[gi*AW +: AW];
            assign dat_a[gi] = m_dat_i[gi*DW +: DW];
            assign sel_a[gi] = m_sel_i[gi*SW +: SW];
            assign cti_a[gi] = m_cti_i[gi*3 +: 3];
        end
    endgenerate

    sdrc_rr_picker #(
        .N  (NUM_M),
        .PW (PW)
    ) u_picker (
        .req   (m_cyc_i),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    assign owner   = PW'(onehot2bin(8'(grant_q)));
    assign ptr_adv = (owner == PW'(NUM_M - 1)) ? '0 : PW'(owner + 1'b1);
    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wd_d    = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        stall   = 1'b0;
        timeout = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_gnt;
                    state_d = OWN;
                end
            end
            OWN: begin
                s_cyc_o = m_cyc_i[owner];
                s_stb_o = m_cyc_i[owner] & m_stb_i[owner];
                s_we_o  = m_we_i[owner];
                s_adr_o = adr_a[owner];
                s_dat_o = dat_a[owner];
                s_sel_o = sel_a[owner];
                s_cti_o = cti_a[owner];
                m_ack_o = grant_q & {NUM_M{s_ack_i & s_stb_o}};
                m_dat_o = s_dat_i;
                // An ACK in the final allowed cycle is not a stall, so it beats the timeout.
                stall   = s_stb_o & ~s_ack_i;
                timeout = (TIMEOUT > 0) && stall && (wd_q == WD_LAST);
                if (stall) begin
                    wd_d = (wd_q == WD_SAT) ? wd_q : wd_q + 1'b1;
                end
                if (!m_cyc_i[owner]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_adv;
                end else if (timeout) begin
                    m_err_o = grant_q;
                    state_d = RELEASE;
                    wd_d    = '0;
                end
            end
            RELEASE: begin
                if (!m_cyc_i[owner]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_adv;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// Directed self-checking bench for sdrc_wb_arbiter (4 masters, TIMEOUT=8).
module tb_sdrc_wb_arbiter;
    import sdrc_arb_pkg::*;

    localparam int NM = 4;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              sys_clk = 1'b0;
    logic              RESETN  = 1'b0;
    logic [NM-1:0]     m_cyc_i = '0;
    logic [NM-1:0]     m_stb_i = '0;
    logic [NM-1:0]     m_we_i  = '0;
    logic [NM*AW-1:0]  m_adr_i = '0;
    logic [NM*DW-1:0]  m_dat_i = '0;
    logic [NM*4-1:0]   m_sel_i = '0;
    logic [NM*3-1:0]   m_cti_i = '0;
    logic [NM-1:0]     m_ack_o;
    logic [NM-1:0]     m_err_o;
    logic [DW-1:0]     m_dat_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [3:0]        s_sel_o;
    logic [2:0]        s_cti_o;
    logic              s_ack_i = 1'b0;
    logic [DW-1:0]     s_dat_i = '0;
    logic [NM-1:0]     grant_o;
    logic              busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    sdrc_wb_arbiter #(
        .NUM_M   (NM),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .sys_clk (sys_clk),
        .RESETN  (RESETN),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_cti_i (m_cti_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_cti_o (s_cti_o),
        .s_ack_i (s_ack_i),
        .s_dat_i (s_dat_i),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [2:0] cti);
        m_cyc_i[k]           = cyc;
        m_stb_i[k]           = stb;
        m_we_i[k]            = we;
        m_adr_i[k*AW +: AW]  = adr;
        m_dat_i[k*DW +: DW]  = 32'hC0DE_0000 | DW'(k);
        m_sel_i[k*4 +: 4]    = 4'hF;
        m_cti_i[k*3 +: 3]    = cti;
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (grant_o !== 4'b0000) begin failures++; $display("FAIL reset_grant act=%b exp=0000", grant_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy act=%b exp=0", busy_o); end
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL reset_s_cyc act=%b exp=0", s_cyc_o); end
        checks++; if (m_ack_o !== 4'b0000 || m_err_o !== 4'b0000) begin failures++; $display("FAIL reset_ack_err ack=%b err=%b exp=0000", m_ack_o, m_err_o); end
        step();
        step();
        RESETN = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < NM; k++) set_m(k, 1'b1, 1'b1, 1'b1, AW'(32'h100 + k * 16), CLASSIC);
        for (int k = 0; k < NM; k++) begin
            step(); #1;
            checks++; if (grant_o !== 4'(1 << k)) begin failures++; $display("FAIL rr_grant%0d act=%b exp=%b", k, grant_o, 4'(1 << k)); end
            checks++; if (s_adr_o !== AW'(32'h100 + k * 16)) begin failures++; $display("FAIL rr_adr%0d act=%h exp=%h", k, s_adr_o, AW'(32'h100 + k * 16)); end
            s_ack_i = 1'b1; #1;
            checks++; if (m_ack_o !== 4'(1 << k)) begin failures++; $display("FAIL rr_ack%0d act=%b exp=%b", k, m_ack_o, 4'(1 << k)); end
            step();
            s_ack_i = 1'b0;
            set_m(k, 1'b0, 1'b0, 1'b0, '0, CLASSIC); #1;
            checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL rr_drop%0d s_cyc act=%b exp=0", k, s_cyc_o); end
            step(); #1;
            checks++; if (s_cyc_o !== 1'b0 || grant_o !== 4'b0000) begin failures++; $display("FAIL rr_gap%0d s_cyc=%b grant=%b exp 0/0000", k, s_cyc_o, grant_o); end
            $display("rr transaction master=%0d", k);
        end
        // Pointer should have wrapped to 0: masters 0 and 3 together must pick 0.
        set_m(0, 1'b1, 1'b1, 1'b0, AW'(32'h10), CLASSIC);
        set_m(3, 1'b1, 1'b1, 1'b0, AW'(32'h30), CLASSIC);
        step(); #1;
        checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL rr_ptr_wrap act=%b exp=0001", grant_o); end
        set_m(0, 1'b0, 1'b0, 1'b0, '0, CLASSIC);
        set_m(3, 1'b0, 1'b0, 1'b0, '0, CLASSIC);
        step(); #1;
        $display("test_round_robin done");
    endtask

    task automatic test_single_write();
        set_m(0, 1'b1, 1'b1, 1'b1, AW'(32'h100), CLASSIC);
        m_dat_i[31:0] = 32'hDEADBEEF;
        #1;
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL sw_latency s_cyc act=%b exp=0", s_cyc_o); end
        step(); #1;
        checks++; if (s_cyc_o !== 1'b1 || grant_o !== 4'b0001) begin failures++; $display("FAIL sw_grant s_cyc=%b grant=%b exp 1/0001", s_cyc_o, grant_o); end
        checks++; if (s_adr_o !== AW'(32'h100) || s_dat_o !== 32'hDEADBEEF || s_we_o !== 1'b1) begin failures++; $display("FAIL sw_route adr=%h dat=%h we=%b exp 100/deadbeef/1", s_adr_o, s_dat_o, s_we_o); end
        checks++; if (m_ack_o !== 4'b0000) begin failures++; $display("FAIL sw_noack act=%b exp=0000", m_ack_o); end
        s_ack_i = 1'b1; #1;
        checks++; if (m_ack_o !== 4'b0001) begin failures++; $display("FAIL sw_ack act=%b exp=0001", m_ack_o); end
        step();
        s_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, CLASSIC); #1;
        checks++; if (m_ack_o !== 4'b0000 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL sw_end ack=%b s_cyc=%b exp 0000/0", m_ack_o, s_cyc_o); end
        step(); #1;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL sw_idle busy act=%b exp=0", busy_o); end
        $display("single write master=0 adr=100 dat=deadbeef");
    endtask

    task automatic test_burst();
        logic [DW-1:0] exp_dat;
        set_m(2, 1'b1, 1'b1, 1'b0, AW'(32'h200), INCR);
        step(); #1;
        checks++; if (grant_o !== 4'b0100) begin failures++; $display("FAIL burst_grant act=%b exp=0100", grant_o); end
        set_m(1, 1'b1, 1'b1, 1'b1, AW'(32'h300), CLASSIC);
        for (int b = 0; b < 4; b++) begin
            m_adr_i[2*AW +: AW] = AW'(32'h200 + b * 4);
            m_cti_i[2*3 +: 3]   = (b == 3) ? EOB : INCR;
            exp_dat = 32'hA5A5_0000 + DW'(b);
            s_dat_i = exp_dat;
            s_ack_i = 1'b1; #1;
            checks++; if (m_ack_o !== 4'b0100) begin failures++; $display("FAIL burst_ack%0d act=%b exp=0100", b, m_ack_o); end
            checks++; if (m_dat_o !== exp_dat) begin failures++; $display("FAIL burst_dat%0d act=%h exp=%h", b, m_dat_o, exp_dat); end
            checks++; if (s_adr_o !== AW'(32'h200 + b * 4)) begin failures++; $display("FAIL burst_adr%0d act=%h exp=%h", b, s_adr_o, AW'(32'h200 + b * 4)); end
            $display("burst beat=%0d master=2 dat=%h", b, exp_dat);
            step();
        end
        s_ack_i = 1'b0;
        set_m(2, 1'b0, 1'b0, 1'b0, '0, CLASSIC); #1;
        checks++; if (m_ack_o !== 4'b0000 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL burst_end ack=%b s_cyc=%b exp 0000/0", m_ack_o, s_cyc_o); end
        step(); #1;
        checks++; if (grant_o !== 4'b0000) begin failures++; $display("FAIL burst_gap grant=%b exp=0000", grant_o); end
        step(); #1;
        checks++; if (grant_o !== 4'b0010 || s_adr_o !== AW'(32'h300)) begin failures++; $display("FAIL burst_next grant=%b adr=%h exp 0010/300", grant_o, s_adr_o); end
        s_ack_i = 1'b1; #1;
        checks++; if (m_ack_o !== 4'b0010) begin failures++; $display("FAIL burst_m1_ack act=%b exp=0010", m_ack_o); end
        step();
        s_ack_i = 1'b0;
        set_m(1, 1'b0, 1'b0, 1'b0, '0, CLASSIC);
        step(); #1;
        $display("test_burst done");
    endtask

    task automatic test_timeout();
        set_m(3, 1'b1, 1'b1, 1'b1, AW'(32'h3F0), CLASSIC);
        step(); #1;
        checks++; if (grant_o !== 4'b1000) begin failures++; $display("FAIL to_grant act=%b exp=1000", grant_o); end
        for (int i = 0; i < TO - 1; i++) begin
            checks++; if (m_err_o !== 4'b0000) begin failures++; $display("FAIL to_early_err stall=%0d act=%b exp=0000", i + 1, m_err_o); end
            step(); #1;
        end
        checks++; if (m_err_o !== 4'b1000) begin failures++; $display("FAIL to_err act=%b exp=1000", m_err_o); end
        step(); #1;
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin failures++; $display("FAIL to_release s_cyc=%b s_stb=%b exp 0/0", s_cyc_o, s_stb_o); end
        checks++; if (m_err_o !== 4'b0000 || busy_o !== 1'b1) begin failures++; $display("FAIL to_pulse err=%b busy=%b exp 0000/1", m_err_o, busy_o); end
        s_ack_i = 1'b1; #1;
        checks++; if (m_ack_o !== 4'b0000) begin failures++; $display("FAIL to_stray_ack act=%b exp=0000", m_ack_o); end
        step();
        set_m(3, 1'b0, 1'b0, 1'b0, '0, CLASSIC);
        step(); #1;
        checks++; if (m_ack_o !== 4'b0000 || busy_o !== 1'b0) begin failures++; $display("FAIL to_idle ack=%b busy=%b exp 0000/0", m_ack_o, busy_o); end
        s_ack_i = 1'b0;
        $display("timeout master=3 stalls=%0d", TO);
    endtask

    task automatic test_ack_wins();
        set_m(0, 1'b1, 1'b1, 1'b1, AW'(32'h040), CLASSIC);
        step(); #1;
        checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL aw_grant act=%b exp=0001", grant_o); end
        for (int i = 0; i < TO - 1; i++) begin
            step(); #1;
        end
        s_ack_i = 1'b1; #1;
        checks++; if (m_ack_o !== 4'b0001 || m_err_o !== 4'b0000) begin failures++; $display("FAIL aw_ack ack=%b err=%b exp 0001/0000", m_ack_o, m_err_o); end
        step();
        s_ack_i = 1'b0; #1;
        for (int i = 0; i < TO - 1; i++) begin
            checks++; if (m_err_o !== 4'b0000) begin failures++; $display("FAIL aw_cleared stall=%0d err=%b exp=0000", i + 1, m_err_o); end
            step(); #1;
        end
        set_m(0, 1'b0, 1'b0, 1'b0, '0, CLASSIC); #1;
        checks++; if (m_err_o !== 4'b0000) begin failures++; $display("FAIL aw_drop err=%b exp=0000", m_err_o); end
        step(); #1;
        $display("ack wins master=0 ack at stall %0d", TO);
    endtask

    task automatic test_reset_mid_burst();
        set_m(2, 1'b1, 1'b1, 1'b0, AW'(32'h280), INCR);
        step(); #1;
        checks++; if (grant_o !== 4'b0100) begin failures++; $display("FAIL rst_pre_grant act=%b exp=0100", grant_o); end
        s_dat_i = 32'h1234_5678;
        s_ack_i = 1'b1; #1;
        checks++; if (m_ack_o !== 4'b0100) begin failures++; $display("FAIL rst_pre_ack act=%b exp=0100", m_ack_o); end
        RESETN = 1'b0; #1;
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_adr_o !== '0) begin failures++; $display("FAIL rst_async_s s_cyc=%b s_stb=%b adr=%h exp 0/0/0", s_cyc_o, s_stb_o, s_adr_o); end
        checks++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin failures++; $display("FAIL rst_async_grant grant=%b busy=%b exp 0000/0", grant_o, busy_o); end
        checks++; if (m_ack_o !== 4'b0000 || m_err_o !== 4'b0000) begin failures++; $display("FAIL rst_async_ack ack=%b err=%b exp 0000/0000", m_ack_o, m_err_o); end
        s_ack_i = 1'b0;
        set_m(2, 1'b0, 1'b0, 1'b0, '0, CLASSIC);
        set_m(0, 1'b1, 1'b1, 1'b0, AW'(32'h0C0), CLASSIC);
        set_m(3, 1'b1, 1'b1, 1'b0, AW'(32'h3C0), CLASSIC);
        step();
        RESETN = 1'b1;
        step(); #1;
        checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL rst_first_grant act=%b exp=0001", grant_o); end
        set_m(0, 1'b0, 1'b0, 1'b0, '0, CLASSIC);
        set_m(3, 1'b0, 1'b0, 1'b0, '0, CLASSIC);
        step();
        step();
        $display("reset mid burst master=2, post-reset grant master=0");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_write();
        test_burst();
        test_timeout();
        test_ack_wins();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdrc_wb_arbiter.md
Name: sdrc_wb_arbiter

Overview:
- N-port round-robin Wishbone arbiter sharing the single Wishbone slave port of the SDRAM controller (sdrc_top) between several masters.
- Grants one master per Wishbone cycle (CYC envelope) and routes its signals to the controller.
- Returns ACK/read data to the owner only.
- Watchdog aborts a hung cycle with ERR so the shared port is never locked.

Parameters:
NUM_M, 4, number of requesting masters (2..8)
AW, 26, address width
DW, 32, data width (application width, matches controller)
TIMEOUT, 255, max cycles from slave STB to ACK before abort; 0 disables watchdog

Ports:
sys_clk  in  1  system (Wishbone) clock
RESETN  in  1  asynchronous active-low reset
m_cyc_i  in  NUM_M  per-master CYC
m_stb_i  in  NUM_M  per-master STB
m_we_i  in  NUM_M  per-master WE
m_adr_i  in  NUM_M*AW  packed addresses, master k at [k*AW +: AW]
m_dat_i  in  NUM_M*DW  packed write data
m_sel_i  in  NUM_M*DW/8  packed byte selects
m_cti_i  in  NUM_M*3  packed cycle type
m_ack_o  out  NUM_M  per-master ACK
m_err_o  out  NUM_M  per-master ERR (timeout)
m_dat_o  out  DW  read data, broadcast (valid only with own ACK)
s_cyc_o, s_stb_o, s_we_o  out  1  to controller
s_adr_o  out  AW  to controller
s_dat_o  out  DW  to controller
s_sel_o  out  DW/8  to controller
s_cti_o  out  3  to controller
s_ack_i  in  1  controller ACK
s_dat_i  in  DW  controller read data
grant_o  out  NUM_M  one-hot current owner (debug/perf)
busy_o  out  1  port owned

Behaviour:
- Reset (RESETN low, async): state IDLE, grant_o=0, rr pointer=0, watchdog=0. All s_* outputs 0; m_ack_o=0, m_err_o=0, busy_o=0. Reset mid-cycle drops s_cyc_o immediately, with no ACK/ERR.
- FSM IDLE -> OWN -> (RELEASE) -> IDLE.
- IDLE: if any m_cyc_i, pick the first requester at or after rr pointer (circular). Register grant_o one-hot; go OWN next edge. Arbitration latency is 1 cycle: request at edge t, s_cyc_o high from t+1.
- OWN: s_* combinationally muxed from owner inputs; s_cyc_o = owner m_cyc_i.
  - m_ack_o[owner] = s_ack_i & owner stb; other ack bits 0; m_dat_o = s_dat_i.
  - Non-owner inputs ignored, never ACKed.
- OWN exit, owner m_cyc_i low: rr pointer = owner+1 mod NUM_M; grant_o cleared; go IDLE. At least 1 idle cycle between owners (s_cyc_o low ≥1 cycle).
- Grant is never preempted while owner CYC is high; bursts (cti 010) stay atomic.
- Watchdog (TIMEOUT>0):
  - Counts cycles where s_stb_o high and s_ack_i low; clears on ACK or STB low.
  - Reaching TIMEOUT: pulse m_err_o[owner] one cycle, force s_cyc_o/s_stb_o low, go RELEASE.
- RELEASE: hold s_cyc_o low until owner drops m_cyc_i, then advance pointer and go IDLE. A late s_ack_i in RELEASE/IDLE is discarded.
- Simultaneous s_ack_i and timeout on the same cycle: ACK wins, counter clears.
- Owner drops CYC while another master requests: new grant after the idle cycle; pointer already advanced.
- Single requester: re-granted each cycle it re-raises CYC (1 idle cycle per CYC).
- Counter width $clog2(TIMEOUT+1); saturating, no wrap.

Decomposition:
- Package sdrc_arb_pkg: arb_state_e enum (IDLE, OWN, RELEASE), CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111), function onehot2bin.
- Sub-module sdrc_rr_picker (combinational circular priority: req vector + pointer -> one-hot grant, valid).
- FSM, mux and watchdog live in the top module.

Test Plan:
- Single master 0 classic write addr 0x100 data 0xDEADBEEF -> s_cyc_o one cycle after m_cyc_i; m_ack_o=4'b0001 coincident with s_ack_i; grant_o=0001.
- Masters 0..3 request together, each 1 write -> grants in order 0,1,2,3. s_cyc_o low ≥1 cycle between; pointer ends at 0.
- Master 2 INCR burst of 4 reads while master 1 requests -> 4 ACKs to master 2 only; m_dat_o matches s_dat_i. Master 1 granted only after master 2 drops CYC.
- TIMEOUT=8, slave never ACKs -> m_err_o[owner] pulses at 8th stall cycle; s_cyc_o low. Later stray s_ack_i produces no m_ack_o.
- ACK and timeout on same cycle (stall 7 then ACK at 8) -> ACK delivered, no ERR.
- RESETN low mid-burst -> all outputs 0 asynchronously. After release, first grant goes to lowest requester from pointer 0.
